sort_job_arbiter: RTL
=====================

Name: sort_job_arbiter

Overview:
- Shares one selection_sort engine among NREQ requesters.
- Round-robin arbitration; captures the granted requester's array and width, then sequences the engine's Start/Done/Ack handshake.
- Returns the sorted array on a shared response bus and reports per-job engine latency.
- Sits between the requester blocks and the single sort engine instance.

Parameters:
NREQ, 4, number of requesters (2..8)
NELEM, 30, array elements (must match engine)
EW, 7, element width in bits
CW, 16, latency counter width

Ports:
Clk  input  1  clock
Reset  input  1  reset, asynchronous, active-high
req  input  NREQ  per-requester job request, level, held until rsp_valid seen
req_width  input  NREQ*5  per-requester element count, slice i = [5i+4:5i]
req_data  input  NREQ*NELEM*EW  per-requester unsorted array, element j of requester i at [(i*NELEM+j)*EW +: EW]
grant  output  NREQ  one-hot owner of current job, 0 when idle
rsp_valid  output  1  response available for the granted requester
rsp_err  output  1  job rejected (width > NELEM), qualified by rsp_valid
rsp_data  output  NELEM*EW  sorted array, same packing as engine Aout
last_cycles  output  CW  engine latency of last accepted job, saturating
srt_width  output  5  to engine width
srt_Start  output  1  to engine Start
srt_Ack  output  1  to engine Ack
srt_Ain  output  NELEM*EW  to engine Ain
srt_Aout  input  NELEM*EW  from engine Aout
srt_Done  input  1  from engine Done

Behaviour:
- Reset values: state IDLE, grant 0, rsp_valid 0, rsp_err 0, rsp_data 0, last_cycles 0, srt_Start 0, srt_Ack 0, srt_width 0, srt_Ain 0, rr pointer = NREQ-1.
- Reset mid-job returns to IDLE immediately; the engine shares Reset, so both restart together.
- States: IDLE, LOAD, WAIT, ACK, CLR, RESP. srt_Start=1 only in LOAD; srt_Ack=1 only in ACK (Moore decodes of the state register).
- IDLE:
  - If any req, pick the first asserted index after the rr pointer (wrapping) and set grant one-hot.
  - Latch that requester's req_width into srt_width and req_data into srt_Ain; both are held constant until the next grant.
  - Update the rr pointer to the winner.
  - If the latched width > NELEM: go to RESP with rsp_err=1 and rsp_data = latched req_data; the engine is not used and last_cycles is unchanged.
  - Otherwise go to LOAD.
- LOAD: one cycle. The engine samples Start on the exiting edge. Clear the latency counter. Go to WAIT.
- WAIT:
  - Increment the latency counter each cycle, saturating at 2^CW-1.
  - On srt_Done==1: capture srt_Aout into rsp_data, copy the counter into last_cycles, go to ACK.
  - srt_Done is never sampled outside WAIT and CLR (it is undefined after reset until the engine's first INI cycle).
- ACK: one cycle with srt_Ack=1. Go to CLR.
- CLR: wait until srt_Done==0 (the engine clears Done one cycle after returning to INI). Then go to RESP with rsp_err=0.
- RESP:
  - rsp_valid=1 and grant held.
  - When req[granted] is sampled 0: clear rsp_valid, rsp_err and grant; go to IDLE.
  - No new grant occurs in the same cycle.
- Requester drops req before RESP: ignored, the job completes, and RESP exits on the first cycle.
- Width 0 or 1 is accepted and forwarded; the engine completes in 2 WAIT cycles.
- Expected WAIT count: w(w+1)/2+1 for w>=2; 2 for w<2.
- Simultaneous requests are resolved by rr order only; a new req from the current owner in RESP is not seen until IDLE.

Decomposition:
- Package sort_pkg: NELEM, EW, width-field size 5, arbiter state encoding (one-hot, 6 bits), packing helper constants.
- Sub-module rr_pick: combinational round-robin picker (inputs req and pointer; outputs one-hot winner and any-request flag).

Test Plan:
- Single job: req[0], width 5, data {9,3,7,1,4,...}. Response is {1,3,4,7,9,...} with the tail unchanged, last_cycles=16, srt_Start high exactly 1 cycle.
- Contention: req[1], req[2] and req[3] asserted together. Grants go in order 1,2,3; then re-asserted req[1] and req[0] are granted 0 then 1 (wrap).
- Width 31 on req[2]: rsp_valid with rsp_err=1, rsp_data equals input, srt_Start never pulses, last_cycles unchanged.
- Width 1 and width 0: rsp_err=0, data unchanged, last_cycles=2. Width 30 with a reversed array gives ascending output and last_cycles=466.
- Reset asserted in WAIT: all outputs return to reset values next cycle. A subsequent job completes correctly.
- Requester holds req 3 extra cycles in RESP: rsp_valid stays 1. Release gives grant=0 on the next cycle, and there is no double-service of the same request.

Source files
------------

// File: rtl/sort_job_arbiter_pkg.sv
// Shared constants and state encoding for the sort job arbiter.
package sort_pkg;

    localparam int unsigned NELEM = 30;           // elements per array, matches the engine
    localparam int unsigned EW    = 7;            // element width in bits
    localparam int unsigned WW    = 5;            // per-requester width field size
    localparam int unsigned AW    = NELEM * EW;   // packed array width

    // One-hot arbiter states.
    typedef enum logic [5:0] {
        StIdle = 6'b000001,
        StLoad = 6'b000010,
        StWait = 6'b000100,
        StAck  = 6'b001000,
        StClr  = 6'b010000,
        StResp = 6'b100000
    } arb_state_e;

endpackage

// File: rtl/sort_job_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request after ptr, wrapping.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] winner,
    output logic            any
);

    logic [PW-1:0] idx;

    // Scan from farthest to nearest so the requester closest after ptr wins last.
    always_comb begin
        winner = '0;
        idx    = '0;
        for (int unsigned k = NREQ; k >= 1; k--) begin
            idx = PW'((32'(ptr) + k) % NREQ);
            if (req[idx]) begin
                winner      = '0;
                winner[idx] = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/sort_job_arbiter.sv
// Shares one selection-sort engine among NREQ requesters with round-robin grants.
module sort_job_arbiter
    import sort_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned NELEM = sort_pkg::NELEM,
    parameter int unsigned EW    = sort_pkg::EW,
    parameter int unsigned CW    = 16
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WW-1:0]       req_width,
    input  logic [NREQ*NELEM*EW-1:0] req_data,
    output logic [NREQ-1:0]          grant,
    output logic                     rsp_valid,
    output logic                     rsp_err,
    output logic [NELEM*EW-1:0]      rsp_data,
    output logic [CW-1:0]            last_cycles,
    output logic [WW-1:0]            srt_width,
    output logic                     srt_Start,
    output logic                     srt_Ack,
    output logic [NELEM*EW-1:0]      srt_Ain,
    input  logic [NELEM*EW-1:0]      srt_Aout,
    input  logic                     srt_Done
);

    localparam int unsigned DW = NELEM * EW;
    localparam int unsigned PW = $clog2(NREQ);

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d, winner;
    logic            any_req;
    logic [PW-1:0]   ptr_q, ptr_d, win_idx;
    logic [WW-1:0]   width_q, width_d, sel_width;
    logic [DW-1:0]   ain_q, ain_d, sel_data;
    logic [DW-1:0]   data_q, data_d;
    logic            err_q, err_d;
    logic [CW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (winner),
        .any    (any_req)
    );

    // Mux out the winning requester's width, array and index.
    always_comb begin
        sel_width = '0;
        sel_data  = '0;
        win_idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (winner[i]) begin
                sel_width = req_width[i*WW +: WW];
                sel_data  = req_data[i*DW +: DW];
                win_idx   = PW'(i);
            end
        end
    end

    // Latency counter saturates rather than wrapping.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

    // Next-state logic for the job sequencer.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        width_d = width_q;
        ain_d   = ain_q;
        data_d  = data_q;
        err_d   = err_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    grant_d = winner;
                    ptr_d   = win_idx;
                    width_d = sel_width;
                    ain_d   = sel_data;
                    // Oversized jobs bypass the engine and echo the input back.
                    if (32'(sel_width) > NELEM) begin
                        err_d   = 1'b1;
                        data_d  = sel_data;
                        state_d = StResp;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_inc;
                if (srt_Done) begin
                    data_d  = srt_Aout;
                    last_d  = cnt_inc;
                    state_d = StAck;
                end
            end
            StAck: begin
                state_d = StClr;
            end
            StClr: begin
                // Engine drops Done one cycle after it returns to its initial state.
                if (!srt_Done) begin
                    err_d   = 1'b0;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (!(|(req & grant_q))) begin
                    grant_d = '0;
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; Reset is shared with the engine.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= PW'(NREQ - 1);
            width_q <= '0;
            ain_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            last_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            width_q <= width_d;
            ain_q   <= ain_d;
            data_q  <= data_d;
            err_q   <= err_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant       = grant_q;
    assign rsp_valid   = (state_q == StResp);
    assign rsp_err     = err_q;
    assign rsp_data    = data_q;
    assign last_cycles = last_q;
    assign srt_width   = width_q;
    assign srt_Ain     = ain_q;
    assign srt_Start   = (state_q == StLoad);
    assign srt_Ack     = (state_q == StAck);

endmodule
